// File: rtl/riscv_pkg.sv
// Shared RV32 constants for the data-memory slice: data/address widths,
// load/store funct3 encodings and the controller state type.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ALEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        DMEM_IDLE = 1'b0,
        DMEM_RESP = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store unit (master) and
// data_mem_ctrl (slave).
interface data_mem_ctrl_if;
    import riscv_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [ALEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane handling: load extract + sign/zero extension,
// store byte mask + merge into the existing word, and format faults
// (misalignment or illegal funct3).
module dmem_lane_align
    import riscv_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] rword,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_word,
    output logic [3:0]      byte_mask,
    output logic            fmt_fault
);

    logic [7:0]      b_sel;
    logic [15:0]     h_sel;
    logic [XLEN-1:0] wrep;

    // Decode the access size, pick lanes, and build load/store words.
    always_comb begin
        load_data  = '0;
        byte_mask  = '0;
        fmt_fault  = 1'b0;
        wrep       = '0;
        store_word = rword;
        b_sel      = rword[{lane, 3'b000} +: 8];
        h_sel      = rword[{lane[1], 4'b0000} +: 16];

        if (we) begin
            case (funct3)
                F3_B: begin
                    byte_mask = 4'b0001 << lane;
                    wrep      = {4{wdata[7:0]}};
                end
                F3_H: begin
                    fmt_fault = lane[0];
                    byte_mask = lane[1] ? 4'b1100 : 4'b0011;
                    wrep      = {2{wdata[15:0]}};
                end
                F3_W: begin
                    fmt_fault = |lane;
                    byte_mask = 4'b1111;
                    wrep      = wdata;
                end
                default: fmt_fault = 1'b1;
            endcase
            if (fmt_fault) byte_mask = '0;
        end else begin
            case (funct3)
                F3_B:  load_data = {{(XLEN-8){b_sel[7]}}, b_sel};
                F3_BU: load_data = {{(XLEN-8){1'b0}}, b_sel};
                F3_H: begin
                    fmt_fault = lane[0];
                    load_data = {{(XLEN-16){h_sel[15]}}, h_sel};
                end
                F3_HU: begin
                    fmt_fault = lane[0];
                    load_data = {{(XLEN-16){1'b0}}, h_sel};
                end
                F3_W: begin
                    fmt_fault = |lane;
                    load_data = rword;
                end
                default: fmt_fault = 1'b1;
            endcase
            if (fmt_fault) load_data = '0;
        end

        for (int unsigned b = 0; b < XLEN/8; b++) begin
            if (byte_mask[b]) store_word[8*b +: 8] = wrep[8*b +: 8];
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: one-outstanding request/response FSM in front of
// a word RAM with byte-lane stores. Optional MMIO LED register at LED_ADDR
// is enabled by defining DMEM_MMIO_EN. BASE_ADDR must be word aligned.
module data_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS = 4096,
    parameter logic [ALEN-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [ALEN-1:0] LED_ADDR    = 32'h8000_0000,
    parameter int unsigned     NUM_LEDS    = 4
)(
    input  logic                clk,
    input  logic                rst,
    data_mem_ctrl_if.slave      bus,
    output logic [NUM_LEDS-1:0] leds_out
);

    localparam int unsigned     AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ALEN-1:0] LAST_IDX = ALEN'(DEPTH_WORDS - 1);

    dmem_state_t     state_q, state_d;
    logic            req_ready, rsp_valid, accept;
    logic [ALEN-1:0] off;
    logic [AW-1:0]   idx;
    logic            in_range;
    logic [XLEN-1:0] mem [DEPTH_WORDS];
    logic [XLEN-1:0] rword, load_data, store_word, rdata_d, rdata_q;
    logic [3:0]      byte_mask;
    logic            fmt_fault, fault, ram_we, err_q;
`ifdef DMEM_MMIO_EN
    logic                is_led, led_we;
    logic [NUM_LEDS-1:0] leds_q;
`endif

    assign off      = bus.req_addr - BASE_ADDR;
    assign idx      = off[AW+1:2];
    assign in_range = (bus.req_addr >= BASE_ADDR) && ({2'b00, off[ALEN-1:2]} <= LAST_IDX);
    assign rword    = mem[idx];
    assign accept   = bus.req_valid && req_ready;
`ifdef DMEM_MMIO_EN
    assign is_led   = (bus.req_addr == LED_ADDR);
`endif

    dmem_lane_align u_align (
        .we         (bus.req_we),
        .funct3     (bus.req_funct3),
        .lane       (off[1:0]),
        .rword      (rword),
        .wdata      (bus.req_wdata),
        .load_data  (load_data),
        .store_word (store_word),
        .byte_mask  (byte_mask),
        .fmt_fault  (fmt_fault)
    );

    // Next-state and handshake outputs for the IDLE/RESP controller.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            DMEM_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) state_d = DMEM_RESP;
            end
            DMEM_RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = DMEM_IDLE;
            end
            default: state_d = DMEM_IDLE;
        endcase
    end

    // Access decode: RAM path first, LED register overrides when it is hit.
    always_comb begin
        fault   = fmt_fault || !in_range;
        ram_we  = accept && bus.req_we && !fault;
        rdata_d = fault ? '0 : load_data;
`ifdef DMEM_MMIO_EN
        led_we  = 1'b0;
        if (is_led) begin
            ram_we  = 1'b0;
            fault   = (bus.req_funct3 != F3_W);
            rdata_d = '0;
            if (!fault) begin
                if (bus.req_we) led_we = accept;
                else            rdata_d[NUM_LEDS-1:0] = leds_q;
            end
        end
`endif
    end

    // State register; reset wins over any same-edge acceptance.
    always_ff @(posedge clk) begin
        if (rst) state_q <= DMEM_IDLE;
        else     state_q <= state_d;
    end

    // Response payload is captured on the acceptance edge and held in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= rdata_d;
            err_q   <= fault;
        end
    end

    // RAM write on the acceptance edge; contents are not reset.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) mem[idx] <= store_word;
    end

`ifdef DMEM_MMIO_EN
    // LED register, written by a word store to LED_ADDR.
    always_ff @(posedge clk) begin
        if (rst)         leds_q <= '0;
        else if (led_we) leds_q <= bus.req_wdata[NUM_LEDS-1:0];
    end
    assign leds_out = leds_q;
`else
    assign leds_out = '0;
`endif

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 4096, SHALL set the number of 32-bit RAM words, which must be a power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, SHALL set the byte address of RAM word 0.
REQ-003 Parameter LED_ADDR, default 32'h8000_0000, SHALL set the MMIO LED register byte address.
REQ-004 Parameter NUM_LEDS, default 4, range 1..32, SHALL set the LED register width.
REQ-005 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-007 req_valid  in  1 and req_ready  out  1 SHALL form the request handshake, where a request is accepted when both are 1 on a rising edge.
REQ-008 req_we  in  1 (1 = store), req_funct3  in  3 (F3_* encoding), req_addr  in  ALEN (byte address) and req_wdata  in  XLEN SHALL be the request payload.
REQ-009 rsp_valid  out  1 and rsp_ready  in  1 SHALL form the response handshake.
REQ-010 rsp_rdata  out  XLEN (load result) and rsp_err  out  1 (access fault) SHALL be the response payload.
REQ-011 leds_out  out  NUM_LEDS SHALL be the LED register value.

Function
REQ-012 The FSM SHALL have two states: IDLE (req_ready=1, rsp_valid=0) and RESP (req_ready=0, rsp_valid=1).
REQ-013 On request acceptance in IDLE, the next state SHALL be RESP, with the response payload registered on that same edge, giving a one-cycle request-to-response latency.
REQ-014 RESP SHALL hold the payload stable until rsp_valid&&rsp_ready, then SHALL return to IDLE, so at most one request is outstanding.
REQ-015 The RAM word index SHALL be (req_addr-BASE_ADDR)>>2, and the access SHALL be in range only when req_addr>=BASE_ADDR and the index is <=DEPTH_WORDS-1.
REQ-016 Loads SHALL be LB/LH/LW/LBU/LHU, sign- or zero-extended to XLEN from the selected byte lane(s).
REQ-017 Stores SHALL be SB/SH/SW, writing only the addressed byte lanes via a per-byte write mask, with other bytes of the word unchanged.
REQ-018 An access SHALL fault (rsp_err=1, rsp_rdata=0, no RAM/LED write) when it is misaligned (H: addr[0]!=0; W: addr[1:0]!=0), out of range, or uses an illegal funct3 (load 3/6/7; store >=3).
REQ-019 Any non-faulting store response SHALL return rsp_rdata=0.
REQ-020 RAM write SHALL occur on the acceptance edge, so a load accepted on any later edge returns the new data.
REQ-021 While in RESP, req_valid SHALL be ignored and no state SHALL change other than by the response handshake.

Reset
REQ-022 While rst=1, the block SHALL force state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0 and leds_out=0, with RAM contents not reset.
REQ-023 rst asserted while in RESP SHALL drop the pending response, while a store already accepted stays written.
REQ-024 rst SHALL take priority over a simultaneous request acceptance, so that request is not performed.

Configuration
REQ-025 With DMEM_MMIO_EN defined, an SW to LED_ADDR SHALL set leds_out=wdata[NUM_LEDS-1:0], and an LW from LED_ADDR SHALL return the zero-extended LED value.
REQ-026 Non-word accesses to LED_ADDR SHALL fault.
REQ-027 With DMEM_MMIO_EN undefined, leds_out SHALL be tied to 0, and LED_ADDR SHALL be treated as ordinary (usually out-of-range) address space.

Structure
REQ-028 XLEN, ALEN and F3_* constants, plus typedef dmem_state_t {DMEM_IDLE, DMEM_RESP}, SHALL reside in riscv_pkg.
REQ-029 Combinational lane extract/extend and store mask/merge SHALL be the sub-module dmem_lane_align; the FSM, RAM and MMIO SHALL stay in data_mem_ctrl.

Verification
REQ-030 The bench SHALL cover: SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp_valid exactly 1 cycle after accept.
REQ-031 The bench SHALL cover: SB 0x80 @0x13, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80ADBEEF.
REQ-032 The bench SHALL cover: LH @0x11 and SW @0x12 -> err=1, rdata=0; a following LW @0x10 is unchanged.
REQ-033 The bench SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready=0, and a req_valid pulse is ignored.
REQ-034 The bench SHALL cover: SW @(DEPTH_WORDS-1)*4 succeeds; SW @DEPTH_WORDS*4 -> err=1.
REQ-035 The bench SHALL cover: with DMEM_MMIO_EN, SW 0xF5 @0x8000_0000 -> leds_out=4'h5; rst in RESP -> rsp_valid=0 and leds_out=0 the next cycle.
